// File: rtl/matrix_frame_decoder_if.sv
// Pin-side and decoded-frame signals of the matrix frame decoder.
interface matrix_frame_decoder_if;
    logic [7:0]  pins_in;
    logic        sample_en;
    logic [15:0] frame;
    logic        frame_valid;
    logic [4:0]  hours;
    logic [5:0]  minutes;
    logic        time_ok;
    logic        locked;
    logic        row_err;
    logic        seq_err;

    modport master (
        output pins_in, sample_en,
        input  frame, frame_valid, hours, minutes,
        input  time_ok, locked, row_err, seq_err
    );

    modport slave (
        input  pins_in, sample_en,
        output frame, frame_valid, hours, minutes,
        output time_ok, locked, row_err, seq_err
    );
endinterface

// File: rtl/matrix_frame_decoder.sv
// Decodes a scanned 4-row matrix display into a 16-bit frame holding
// an hours/minutes reading, with stability filtering and lock tracking.
module matrix_frame_decoder #(
    parameter int unsigned STABLE_CNT = 1,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    matrix_frame_decoder_if.slave bus
);

    localparam logic [0:0]  HUNT  = 1'b0;
    localparam logic [0:0]  TRACK = 1'b1;
    localparam logic [3:0]  STB   = 4'(STABLE_CNT);
    localparam logic [15:0] TMO   = 16'(TIMEOUT);

    logic [7:0]  sync1;
    logic [7:0]  sync2;
    logic [7:0]  prev;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        acc;
    logic [1:0]  row;
    logic        legal;
    logic        blank;
    logic [3:0]  col;
    logic [0:0]  state;
    logic [1:0]  exp_row;
    logic [15:0] tmo;
    logic [3:0]  part0;
    logic [3:0]  part1;
    logic [3:0]  part2;
    logic [15:0] nf;
    logic [15:0] frame_q;
    logic [4:0]  hours_q;
    logic [5:0]  minutes_q;
    logic        time_ok_q;
    logic        locked_q;
    logic        fv_q;
    logic        row_err_q;
    logic        seq_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.pins_in;
            sync2 <= sync1;
        end
    end

    // Run length saturates at STB so a long steady run is accepted once.
    always_comb begin
        cnt_nxt = cnt;
        if (sync2 != prev)
            cnt_nxt = 4'd1;
        else if (cnt != STB)
            cnt_nxt = cnt + 4'd1;
    end

    assign acc = bus.sample_en && (cnt_nxt == STB)
                 && ((sync2 != prev) || (cnt != STB));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            prev <= '0;
        end else if (bus.sample_en) begin
            cnt  <= cnt_nxt;
            prev <= sync2;
        end
    end

    always_comb begin
        row   = 2'd0;
        legal = 1'b1;
        blank = 1'b0;
        case (sync2[7:4])
            4'b1110: row = 2'd0;
            4'b1101: row = 2'd1;
            4'b1011: row = 2'd2;
            4'b0111: row = 2'd3;
            4'b0000: blank = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    assign col = sync2[3:0];
    assign nf  = {col, part2, part1, part0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            exp_row   <= '0;
            tmo       <= '0;
            part0     <= '0;
            part1     <= '0;
            part2     <= '0;
            frame_q   <= '0;
            hours_q   <= '0;
            minutes_q <= '0;
            time_ok_q <= 1'b0;
            locked_q  <= 1'b0;
            fv_q      <= 1'b0;
            row_err_q <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            fv_q      <= 1'b0;
            row_err_q <= 1'b0;
            seq_err_q <= 1'b0;
            if (acc) begin
                tmo <= '0;
                if (blank || !legal) begin
                    row_err_q <= !legal;
                    state     <= HUNT;
                    exp_row   <= '0;
                    locked_q  <= 1'b0;
                end else if (state == HUNT) begin
                    if (row == 2'd0) begin
                        part0   <= col;
                        exp_row <= 2'd1;
                        state   <= TRACK;
                    end
                end else if (row == exp_row) begin
                    exp_row <= exp_row + 2'd1;
                    case (row)
                        2'd0: part0 <= col;
                        2'd1: part1 <= col;
                        2'd2: part2 <= col;
                        default: begin
                            frame_q   <= nf;
                            hours_q   <= nf[10:6];
                            minutes_q <= nf[5:0];
                            time_ok_q <= (nf[10:6] < 5'd24)
                                         && (nf[5:0] < 6'd60)
                                         && (nf[15:11] == 5'd0);
                            fv_q      <= 1'b1;
                            locked_q  <= 1'b1;
                        end
                    endcase
                end else begin
                    seq_err_q <= 1'b1;
                    locked_q  <= 1'b0;
                    if (row == 2'd0) begin
                        part0   <= col;
                        exp_row <= 2'd1;
                    end else begin
                        state   <= HUNT;
                        exp_row <= '0;
                    end
                end
            end else if (bus.sample_en && state == TRACK) begin
                if (tmo == TMO - 16'd1) begin
                    tmo      <= '0;
                    state    <= HUNT;
                    exp_row  <= '0;
                    locked_q <= 1'b0;
                end else begin
                    tmo <= tmo + 16'd1;
                end
            end
        end
    end

    assign bus.frame       = frame_q;
    assign bus.frame_valid = fv_q;
    assign bus.hours       = hours_q;
    assign bus.minutes     = minutes_q;
    assign bus.time_ok     = time_ok_q;
    assign bus.locked      = locked_q;
    assign bus.row_err     = row_err_q;
    assign bus.seq_err     = seq_err_q;

endmodule

// File: tb/tb_matrix_frame_decoder.sv
// Bench for matrix_frame_decoder: two parameterizations share the pins and
// are compared each cycle with a frame-level reference model.
module tb_matrix_frame_decoder;

    localparam int SA = 1;
    localparam int TA = 255;
    localparam int SB = 3;
    localparam int TB = 20;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [7:0] pins = '0;
    logic       en   = 1'b0;

    int n_chk = 0;
    int n_bad = 0;
    int fa, sa, ra, fb, eb;
    logic last_fv;

    matrix_frame_decoder_if ia ();
    matrix_frame_decoder_if ib ();

    assign ia.pins_in   = pins;
    assign ia.sample_en = en;
    assign ib.pins_in   = pins;
    assign ib.sample_en = en;

    matrix_frame_decoder #(.STABLE_CNT(SA), .TIMEOUT(TA)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia)
    );

    matrix_frame_decoder #(.STABLE_CNT(SB), .TIMEOUT(TB)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: synchronizer delay, run-length filter, frame builder.
    logic [7:0] p1, p2;
    logic [7:0] m_last [2];
    int m_run [2];
    int ncap [2];
    int idle [2];
    int nib [2][4];
    int m_frame [2];
    int m_hours [2];
    int m_min [2];
    int m_tok [2];
    int m_lock [2];
    int m_fv [2];
    int m_re [2];
    int m_se [2];

    function automatic int stab(int k);
        return (k == 0) ? SA : SB;
    endfunction

    function automatic int tlim(int k);
        return (k == 0) ? TA : TB;
    endfunction

    function automatic int row_of(logic [3:0] s);
        case (s)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            4'b0000: return 4;
            default: return 5;
        endcase
    endfunction

    function automatic logic [3:0] rowsel(int r);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << r);
    endfunction

    task automatic model_reset();
        p1 = '0;
        p2 = '0;
        for (int k = 0; k < 2; k++) begin
            m_last[k] = '0;
            m_run[k] = 0;
            ncap[k] = -1;
            idle[k] = 0;
            m_frame[k] = 0;
            m_hours[k] = 0;
            m_min[k] = 0;
            m_tok[k] = 0;
            m_lock[k] = 0;
            m_fv[k] = 0;
            m_re[k] = 0;
            m_se[k] = 0;
        end
    endtask

    task automatic model_step(int k, logic [7:0] v, logic e);
        int r;
        int f;
        m_fv[k] = 0;
        m_re[k] = 0;
        m_se[k] = 0;
        if (!e) return;
        if (v == m_last[k]) m_run[k]++;
        else begin
            m_last[k] = v;
            m_run[k] = 1;
        end
        if (m_run[k] != stab(k)) begin
            if (ncap[k] >= 0) begin
                idle[k]++;
                if (idle[k] >= tlim(k)) begin
                    ncap[k] = -1;
                    m_lock[k] = 0;
                    idle[k] = 0;
                end
            end
            return;
        end
        idle[k] = 0;
        r = row_of(v[7:4]);
        if (r >= 4) begin
            m_re[k] = (r == 5);
            ncap[k] = -1;
            m_lock[k] = 0;
        end else if (ncap[k] < 0) begin
            if (r == 0) begin
                nib[k][0] = v[3:0];
                ncap[k] = 1;
            end
        end else if (r == ncap[k]) begin
            nib[k][r] = v[3:0];
            ncap[k]++;
            if (ncap[k] == 4) begin
                f = nib[k][0] + 16 * nib[k][1]
                    + 256 * nib[k][2] + 4096 * nib[k][3];
                m_frame[k] = f;
                m_hours[k] = (f / 64) % 32;
                m_min[k] = f % 64;
                m_tok[k] = (m_hours[k] < 24 && m_min[k] < 60
                            && f < 2048);
                m_fv[k] = 1;
                m_lock[k] = 1;
                ncap[k] = 0;
            end
        end else begin
            m_se[k] = 1;
            m_lock[k] = 0;
            if (r == 0) begin
                nib[k][0] = v[3:0];
                ncap[k] = 1;
            end else begin
                ncap[k] = -1;
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rst) model_reset();
        else begin
            model_step(0, p2, en);
            model_step(1, p2, en);
            p2 = p1;
            p1 = pins;
        end
        chk("a_frame", ia.frame, m_frame[0]);
        chk("a_fv", ia.frame_valid, m_fv[0]);
        chk("a_hours", ia.hours, m_hours[0]);
        chk("a_min", ia.minutes, m_min[0]);
        chk("a_tok", ia.time_ok, m_tok[0]);
        chk("a_lock", ia.locked, m_lock[0]);
        chk("a_rerr", ia.row_err, m_re[0]);
        chk("a_serr", ia.seq_err, m_se[0]);
        chk("b_frame", ib.frame, m_frame[1]);
        chk("b_fv", ib.frame_valid, m_fv[1]);
        chk("b_hours", ib.hours, m_hours[1]);
        chk("b_min", ib.minutes, m_min[1]);
        chk("b_tok", ib.time_ok, m_tok[1]);
        chk("b_lock", ib.locked, m_lock[1]);
        chk("b_rerr", ib.row_err, m_re[1]);
        chk("b_serr", ib.seq_err, m_se[1]);
    end

    task automatic clr();
        fa = 0;
        sa = 0;
        ra = 0;
        fb = 0;
        eb = 0;
    endtask

    task automatic cyc(input logic [7:0] v, input logic e);
        @(negedge clk);
        last_fv = ia.frame_valid;
        fa += int'(ia.frame_valid);
        sa += int'(ia.seq_err);
        ra += int'(ia.row_err);
        fb += int'(ib.frame_valid);
        eb += int'(ib.row_err) + int'(ib.seq_err);
        #1;
        pins = v;
        en = e;
    endtask

    task automatic row4(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
        cyc(a, 1'b1);
        cyc(b, 1'b1);
        cyc(c, 1'b1);
        cyc(d, 1'b1);
    endtask

    task automatic hold(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) cyc(v, 1'b1);
    endtask

    logic [7:0] v;
    int row;
    int nh;
    int kind;
    int lat;

    initial begin
        clr();
        hold(8'h00, 3);
        chk("rst_frame", ia.frame, 0);
        chk("rst_lock", ia.locked, 0);
        chk("rst_fv", ia.frame_valid, 0);
        rst = 1'b0;

        clr();
        for (int i = 0; i < 5; i++) row4(8'hE2, 8'hD2, 8'hB3, 8'h70);
        chk("d1_fvcnt", fa, 4);
        hold(8'h70, 3);
        chk("d1_frame", ia.frame, 16'h0322);
        chk("d1_hours", ia.hours, 12);
        chk("d1_min", ia.minutes, 34);
        chk("d1_tok", ia.time_ok, 1);
        chk("d1_lock", ia.locked, 1);

        clr();
        cyc(8'hE2, 1'b1);
        cyc(8'hB3, 1'b1);
        hold(8'hB3, 4);
        chk("d2_serr", sa, 1);
        chk("d2_lock", ia.locked, 0);
        chk("d2_fv", fa, 0);
        chk("d2_frame", ia.frame, 16'h0322);

        row4(8'hE2, 8'hD2, 8'hB3, 8'h70);
        row4(8'hE2, 8'hD2, 8'hB3, 8'h70);
        hold(8'h70, 3);
        chk("d3_lock0", ia.locked, 1);
        clr();
        hold(8'hC2, 4);
        chk("d3_rerr", ra, 1);
        chk("d3_lock", ia.locked, 0);
        clr();
        row4(8'hE2, 8'hD2, 8'hB3, 8'h70);
        hold(8'h70, 3);
        chk("d3_fv", fa, 1);

        cyc(8'hEA, 1'b1);
        cyc(8'hD4, 1'b1);
        cyc(8'hB6, 1'b1);
        cyc(8'h70, 1'b1);
        lat = 0;
        for (int i = 1; i <= 5; i++) begin
            cyc(8'h70, 1'b1);
            if (last_fv && lat == 0) lat = i;
        end
        chk("d4_lat", lat, SA + 2);
        chk("d4_frame", ia.frame, 16'h064A);
        chk("d4_hours", ia.hours, 25);
        chk("d4_min", ia.minutes, 10);
        chk("d4_tok", ia.time_ok, 0);

        hold(8'h00, 4);
        hold(8'hE2, 3);
        hold(8'hD2, 3);
        hold(8'hB3, 3);
        hold(8'h70, 3);
        for (int i = 0; i < 2; i++) begin
            hold(8'hE1, 2);
            hold(8'hD1, 2);
        end
        chk("d5_lock1", ib.locked, 1);
        clr();
        for (int i = 0; i < 5; i++) begin
            hold(8'hB1, 2);
            hold(8'h71, 2);
            hold(8'hE1, 2);
            hold(8'hD1, 2);
        end
        chk("d5_lock0", ib.locked, 0);
        chk("d5_err", eb, 0);
        chk("d5_fv", fb, 0);

        cyc(8'hE2, 1'b1);
        cyc(8'hD2, 1'b1);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(8'hD2, 1'b1);
            chk("d6_rst", {ia.frame, ia.hours, ia.minutes,
                           ia.time_ok, ia.locked, ia.frame_valid,
                           ia.row_err, ia.seq_err}, 0);
        end
        rst = 1'b0;
        clr();
        cyc(8'hB3, 1'b1);
        cyc(8'h70, 1'b1);
        row4(8'hE5, 8'hD1, 8'hB0, 8'h70);
        hold(8'h70, 4);
        chk("d6_fv", fa, 1);
        chk("d6_frame", ia.frame, 16'h0015);

        for (int f = 0; f < 200; f++) begin
            kind = $urandom_range(0, 19);
            for (int r = 0; r < 4; r++) begin
                row = r;
                if (kind == 0 && r == 1) row = 2;
                v = {rowsel(row), 4'($urandom_range(0, 15))};
                if (kind == 1 && r == 2) v[7:4] = 4'h0;
                if (kind == 2 && r == 2) v[7:4] = 4'b1001;
                nh = $urandom_range(1, 4);
                for (int h = 0; h < nh; h++)
                    cyc(v, $urandom_range(0, 7) != 0);
            end
            if (kind == 3) hold(pins, 25);
            if (kind == 4) begin
                rst = 1'b1;
                cyc(pins, 1'b1);
                rst = 1'b0;
            end
        end
        hold(pins, 4);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/matrix_frame_decoder.md
MATRIX_FRAME_DECODER -- requirements
Module: matrix_frame_decoder

Interface
REQ-001 Parameter: STABLE_CNT, default 1, number of consecutive identical qualified samples before a row is accepted (range 1..15).
REQ-002 Parameter: TIMEOUT, default 255, number of qualified samples without an accepted row before lock is dropped (range 1..65535).
REQ-003 clk  input  1  clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 pins_in  input  8  scanned display pins; [7:4] row selects, active-low one-hot; [3:0] column data for the selected row, active-high.
REQ-006 sample_en  input  1  sample qualifier; the stability filter and the FSM advance only in cycles where it is 1.
REQ-007 frame  output  16  last complete frame; nibble n = columns of row n.
REQ-008 frame_valid  output  1  one-cycle pulse on each frame commit.
REQ-009 hours  output  5  frame[10:6], registered at commit.
REQ-010 minutes  output  6  frame[5:0], registered at commit.
REQ-011 time_ok  output  1  committed frame has hours<24, minutes<60 and frame[15:11]==0.
REQ-012 locked  output  1  a clean frame has been received since the last error, blank or timeout.
REQ-013 row_err  output  1  one-cycle pulse on an illegal row pattern.
REQ-014 seq_err  output  1  one-cycle pulse on an out-of-order row.

Function
REQ-015 pins_in shall pass through a 2-flop synchronizer clocked every clk, independent of sample_en.
REQ-016 Row decode of synchronized [7:4]: 1110=row0, 1101=row1, 1011=row2, 0111=row3, 0000=blank; every other value is illegal.
REQ-017 Stability: a {row, cols} value is accepted after STABLE_CNT consecutive qualified samples of identical pins, once per contiguous run; any change in the 8 bits restarts the count.
REQ-018 FSM states: HUNT, TRACK; expected-row register exp[1:0].
REQ-019 HUNT: an accepted row0 stores its nibble, sets exp=1 and moves to TRACK; other accepted rows are ignored without error.
REQ-020 TRACK: an accepted row==exp stores its nibble and sets exp=exp+1 (mod 4).
REQ-021 TRACK, accepted row3==exp: commit all 4 nibbles to frame, update hours/minutes/time_ok, pulse frame_valid, set locked=1, set exp=0, stay in TRACK.
REQ-022 TRACK, accepted row!=exp: pulse seq_err, discard the partial frame, clear locked; if that row is row0, restart capture (exp=1, TRACK); otherwise go to HUNT.
REQ-023 Accepted blank, any state: discard the partial frame, clear locked, go to HUNT, no error pulse.
REQ-024 Accepted illegal pattern, any state: pulse row_err, discard the partial frame, clear locked, go to HUNT.
REQ-025 Timeout counter: counts qualified samples with no acceptance in TRACK, saturating; reaching TIMEOUT goes to HUNT and clears locked, no error pulse.
REQ-026 frame, hours, minutes and time_ok change only at commit; errors never alter them.
REQ-027 Latency, sample_en held 1: frame_valid asserts STABLE_CNT+2 clk cycles after the row3 value first appears on pins_in.
REQ-028 sample_en=0: the filter count, FSM, timeout counter and all outputs hold; pulses are not stretched.

Reset
REQ-029 rst asserted: synchronizer=0, filter count=0, FSM=HUNT, exp=0, timeout=0; frame=0, hours=0, minutes=0, time_ok=0, locked=0, all pulses 0.
REQ-030 rst asserted mid-frame: the partial frame is discarded immediately; capture resumes only on the first accepted row0 after release.

Verification
REQ-031 Stimulus 0xE2,0xD2,0xB3,0x70 repeated each clk, STABLE_CNT=1 -> frame=0x0322, hours=12, minutes=34, time_ok=1, frame_valid pulses every 4 cycles, locked=1.
REQ-032 Stimulus 0xE2,0xB3 (row1 skipped) -> seq_err pulses once, locked=0, no frame_valid, frame unchanged.
REQ-033 Stimulus 0xC2 inside a locked stream -> row_err pulses once, locked=0; next full row0..row3 sequence -> frame_valid.
REQ-034 Stimulus frame {5'b0, 5'd25, 6'd10} -> frame_valid pulses, hours=25, time_ok=0.
REQ-035 STABLE_CNT=3, each row held 2 samples -> no acceptance, no frame_valid; after TIMEOUT samples locked=0 with no error pulse.
REQ-036 rst pulsed after row1 of a frame, then a full frame -> all outputs 0 during reset; frame_valid only on the completed post-reset frame.
